wbu: RTL and testbench
======================

# wbu

Write-back unit: final pipeline stage, directly downstream of the memory stage. Holds one retiring instruction in a single-entry buffer and selects write-back data (load result or execute result). Retires it in one commit handshake: register-file write, CSR write strobe, commit/trace port and retire counter all fire in the same cycle. Also exports the buffered destination register so the decoder can detect RAW hazards.

## Interface
- XLEN, 32, datapath width
- CNT_W, 64, retire-counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_last  in  1  memory stage has an instruction
- ready_last  out  1  wbu can accept this cycle
- pc, inst  in  XLEN  instruction address / encoding
- R_wen  in  1  instruction writes a GPR
- rd  in  5  destination GPR
- mem_ren  in  1  instruction is a load
- MEM_Rdata  in  XLEN  extended load data
- Ex_result  in  XLEN  ALU / address result
- csr_wen  in  4  one-hot CSR write select (bit map owned by CSR file)
- csrs  in  XLEN  CSR write value
- jump_flag  in  1  instruction redirected control flow
- commit_valid  out  1  buffered instruction ready to retire
- commit_ready  in  1  trace/difftest consumer accepts
- commit_pc, commit_inst  out  XLEN  retiring instruction
- commit_jump  out  1  buffered jump_flag
- rf_wen  out  1  GPR write strobe
- rf_waddr  out  5  GPR index
- rf_wdata  out  XLEN  GPR data
- csr_wen_o  out  4  CSR write strobe vector
- csr_wdata  out  XLEN  CSR data
- hz_valid  out  1  buffered instruction will write rd_q (rd_q≠0)
- hz_rd  out  5  rd_q when hz_valid, else 0
- instret  out  CNT_W  retired-instruction count

## Operation
- Two states: EMPTY (valid_q=0), FULL (valid_q=1); commit_valid = valid_q.
- ready_last = !valid_q | commit_ready (combinational; full throughput with ready held high).
- accept = valid_last & ready_last; fire = valid_q & commit_ready.
- On accept: capture pc, inst, R_wen, rd, jump_flag, csr_wen, csrs; wdata_q = mem_ren ? MEM_Rdata : Ex_result (select done at capture).
- Transitions: EMPTY→FULL on accept; FULL→EMPTY on fire & !valid_last; FULL→FULL with new payload on fire & valid_last; FULL holds payload while !commit_ready.
- rf_wen = fire & R_wen_q & (rd_q≠0); rf_waddr = rd_q; rf_wdata = wdata_q. Write to x0 never strobes.
- csr_wen_o = fire ? csr_wen_q : 0; csr_wdata = csrs_q.
- instret += 1 on fire; wraps modulo 2^CNT_W to 0.
- Payload registers not cleared on reset; only valid_q and instret are. Strobe outputs are gated so stale payload never writes.

## Timing
- Reset (async assert): valid_q=0, instret=0. Thus commit_valid=0, rf_wen=0, csr_wen_o=0, hz_valid=0, hz_rd=0, ready_last=1. Other outputs don't-care.
- Latency: accepted at edge N → commit_valid high after edge N; retire writes land at edge N+1 if commit_ready high.
- All write strobes are combinational from valid_q & commit_ready; the consumer samples on the edge.
- commit_valid, once high, stays high with stable payload until fire (no retraction).
- Reset asserted mid-FULL: instruction dropped, never retired, instret cleared immediately.
- Simultaneous fire and accept: old instruction retires, new one captured on same edge; instret +1.

## Structure
- Shared package (cpu_pkg): XLEN, REG_ADDR_W=5, CSR_WEN_W=4, one-hot CSR-select constants.
- Single module; no sub-module (buffer + counter are trivial). Optional: instret counter as `wbu_cnt` if reused by CSR file.

## Test plan
- Reset release, valid_last=0 → ready_last=1, commit_valid=0, instret=0, no strobes.
- Load: mem_ren=1, MEM_Rdata=0xDEADBEEF, Ex_result=0x80000010, rd=5, R_wen=1, commit_ready=1 → next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, instret=1 after edge.
- ALU to x0: R_wen=1, rd=0, Ex_result=0x1234 → commit fires, rf_wen=0, hz_valid=0, instret increments.
- Backpressure: commit_ready=0 for 3 cycles with valid_last=1 → ready_last=0, payload stable, no strobes; release → one retire, next instruction accepted same edge.
- Back-to-back 4 instructions, commit_ready=1 → one retire per cycle, instret=4, csr_wen=4'b0010 instruction gives csr_wen_o=4'b0010 only in its fire cycle.
- Async rst pulse while FULL, preset instret=2^64-1 wrap check → prior fire wraps instret to 0; rst clears commit_valid without waiting for clk edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types: datapath widths, CSR write-select
// encodings and the write-back buffer state.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CSR_WEN_W  = 4;

  // One-hot CSR write selects; the bit assignment belongs to the CSR file.
  localparam logic [CSR_WEN_W-1:0] CSR_SEL_NONE   = 4'b0000;
  localparam logic [CSR_WEN_W-1:0] CSR_SEL_MSTATUS = 4'b0001;
  localparam logic [CSR_WEN_W-1:0] CSR_SEL_MTVEC   = 4'b0010;
  localparam logic [CSR_WEN_W-1:0] CSR_SEL_MEPC    = 4'b0100;
  localparam logic [CSR_WEN_W-1:0] CSR_SEL_MCAUSE  = 4'b1000;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wbu_cnt.sv
// Free-running retire counter: increments on each retire, wraps modulo 2^W.
module wbu_cnt #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wbu.sv
// Write-back unit: single-entry retire buffer; register-file write, CSR write,
// commit port and retire counter all fire on the same commit handshake.
module wbu
  import cpu_pkg::*;
#(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_last,
  output logic                  ready_last,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       inst,
  input  logic                  R_wen,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_ren,
  input  logic [XLEN-1:0]       MEM_Rdata,
  input  logic [XLEN-1:0]       Ex_result,
  input  logic [CSR_WEN_W-1:0]  csr_wen,
  input  logic [XLEN-1:0]       csrs,
  input  logic                  jump_flag,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output logic [XLEN-1:0]       commit_pc,
  output logic [XLEN-1:0]       commit_inst,
  output logic                  commit_jump,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [CSR_WEN_W-1:0]  csr_wen_o,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  hz_valid,
  output logic [REG_ADDR_W-1:0] hz_rd,
  output logic [CNT_W-1:0]      instret
);

  wb_state_e state_q, state_d;
  logic      accept, fire;

  logic [XLEN-1:0]       pc_q, inst_q, wdata_q, csrs_q;
  logic                  r_wen_q, jump_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [CSR_WEN_W-1:0]  csr_wen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WB_EMPTY;
    else     state_q <= state_d;
  end

  // A fire with a new instruction waiting keeps the buffer FULL with fresh payload.
  always_comb begin
    state_d    = state_q;
    ready_last = (state_q == WB_EMPTY) || commit_ready;
    accept     = valid_last && ready_last;
    fire       = (state_q == WB_FULL) && commit_ready;
    case (state_q)
      WB_EMPTY: if (accept) state_d = WB_FULL;
      WB_FULL:  if (fire && !valid_last) state_d = WB_EMPTY;
      default:  state_d = WB_EMPTY;
    endcase
  end

  // Payload is intentionally not reset; every strobe below is gated by fire.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q      <= pc;
      inst_q    <= inst;
      r_wen_q   <= R_wen;
      rd_q      <= rd;
      jump_q    <= jump_flag;
      csr_wen_q <= csr_wen;
      csrs_q    <= csrs;
      wdata_q   <= mem_ren ? MEM_Rdata : Ex_result;
    end
  end

  assign commit_valid = (state_q == WB_FULL);
  assign commit_pc    = pc_q;
  assign commit_inst  = inst_q;
  assign commit_jump  = jump_q;

  assign rf_wen    = fire && r_wen_q && (rd_q != '0);
  assign rf_waddr  = rd_q;
  assign rf_wdata  = wdata_q;
  assign csr_wen_o = fire ? csr_wen_q : '0;
  assign csr_wdata = csrs_q;

  assign hz_valid = commit_valid && r_wen_q && (rd_q != '0);
  assign hz_rd    = hz_valid ? rd_q : '0;

  wbu_cnt #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fire),
    .cnt_o (instret)
  );

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: table-driven vectors feed a scoreboard that
// is drained on every commit handshake; hand sequences cover the corner cases.
module tb_wbu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        valid_last = 1'b0, commit_ready = 1'b0;
  logic        R_wen = 1'b0, mem_ren = 1'b0, jump_flag = 1'b0;
  logic [4:0]  rd = '0;
  logic [3:0]  csr_wen = '0;
  logic [31:0] pc = '0, inst = '0, MEM_Rdata = '0, Ex_result = '0, csrs = '0;

  logic        ready_last, commit_valid, commit_jump, rf_wen, hz_valid;
  logic [31:0] commit_pc, commit_inst, rf_wdata, csr_wdata;
  logic [4:0]  rf_waddr, hz_rd;
  logic [3:0]  csr_wen_o;
  logic [63:0] instret;

  // Narrow-counter copy of the DUT sharing all inputs, used to observe wrap.
  logic        w_ready_last, w_commit_valid, w_commit_jump, w_rf_wen, w_hz_valid;
  logic [31:0] w_commit_pc, w_commit_inst, w_rf_wdata, w_csr_wdata;
  logic [4:0]  w_rf_waddr, w_hz_rd;
  logic [3:0]  w_csr_wen_o;
  logic [2:0]  w_instret;

  wbu dut (
    .clk(clk), .rst(rst), .valid_last(valid_last), .ready_last(ready_last),
    .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd), .mem_ren(mem_ren),
    .MEM_Rdata(MEM_Rdata), .Ex_result(Ex_result), .csr_wen(csr_wen), .csrs(csrs),
    .jump_flag(jump_flag), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_jump(commit_jump),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wen_o(csr_wen_o), .csr_wdata(csr_wdata), .hz_valid(hz_valid),
    .hz_rd(hz_rd), .instret(instret)
  );

  wbu #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .valid_last(valid_last), .ready_last(w_ready_last),
    .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd), .mem_ren(mem_ren),
    .MEM_Rdata(MEM_Rdata), .Ex_result(Ex_result), .csr_wen(csr_wen), .csrs(csrs),
    .jump_flag(jump_flag), .commit_valid(w_commit_valid), .commit_ready(commit_ready),
    .commit_pc(w_commit_pc), .commit_inst(w_commit_inst), .commit_jump(w_commit_jump),
    .rf_wen(w_rf_wen), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
    .csr_wen_o(w_csr_wen_o), .csr_wdata(w_csr_wdata), .hz_valid(w_hz_valid),
    .hz_rd(w_hz_rd), .instret(w_instret)
  );

  typedef struct {
    logic [31:0] pc, inst, mdata, exr, csrs;
    logic        mem_ren, rwen, jump;
    logic [4:0]  rd;
    logic [3:0]  csrw;
    logic [31:0] exp_wdata;
    logic        exp_rfw;
  } vec_t;

  typedef struct {
    logic [31:0] pc, inst, wdata, csrs;
    logic [4:0]  rd;
    logic        rfw;
    logic [3:0]  csrw;
    logic        jump;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t cur_exp;
  logic [63:0] exp_cnt = '0;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] p, input logic [31:0] i,
                               input logic mr, input logic [31:0] md,
                               input logic [31:0] ex, input logic rw,
                               input logic [4:0] r, input logic [3:0] cw,
                               input logic [31:0] cs, input logic j,
                               input logic [31:0] ew, input logic erf);
    vec_t v;
    v.pc = p; v.inst = i; v.mem_ren = mr; v.mdata = md; v.exr = ex; v.rwen = rw;
    v.rd = r; v.csrw = cw; v.csrs = cs; v.jump = j; v.exp_wdata = ew; v.exp_rfw = erf;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    valid_last = 1'b1;
    pc = v.pc; inst = v.inst; mem_ren = v.mem_ren; MEM_Rdata = v.mdata;
    Ex_result = v.exr; R_wen = v.rwen; rd = v.rd; csr_wen = v.csrw;
    csrs = v.csrs; jump_flag = v.jump;
    cur_exp.pc = v.pc; cur_exp.inst = v.inst; cur_exp.wdata = v.exp_wdata;
    cur_exp.csrs = v.csrs; cur_exp.rd = v.rd; cur_exp.rfw = v.exp_rfw;
    cur_exp.csrw = v.csrw; cur_exp.jump = v.jump;
  endtask

  // Scoreboard: pop and compare on fire, push on accept, one line per retire.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_cnt = '0;
    end else begin
      chk("instret", instret, exp_cnt);
      chk("instret_wrap", {61'd0, w_instret}, {61'd0, exp_cnt[2:0]});
      chk("ready_last", {63'd0, ready_last}, {63'd0, (!commit_valid) || commit_ready});
      if (commit_valid && sb_q.size() != 0) begin
        chk("hz_valid", {63'd0, hz_valid}, {63'd0, sb_q[0].rfw});
        chk("hz_rd", {59'd0, hz_rd}, {59'd0, sb_q[0].rfw ? sb_q[0].rd : 5'd0});
      end else begin
        chk("hz_idle", {58'd0, hz_valid, hz_rd}, 64'd0);
      end
      if (commit_valid && commit_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_retire", {32'd0, commit_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("retire pc=%08h inst=%08h rf_wen=%0b rd=%0d wdata=%08h csr_wen=%04b instret=%0d",
                   commit_pc, commit_inst, rf_wen, rf_waddr, rf_wdata, csr_wen_o, instret);
          chk("commit_pc", commit_pc, e.pc);
          chk("commit_inst", commit_inst, e.inst);
          chk("commit_jump", {63'd0, commit_jump}, {63'd0, e.jump});
          chk("rf_wen", {63'd0, rf_wen}, {63'd0, e.rfw});
          chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
          chk("rf_wdata", rf_wdata, e.wdata);
          chk("csr_wen_o", {60'd0, csr_wen_o}, {60'd0, e.csrw});
          chk("csr_wdata", csr_wdata, e.csrs);
          exp_cnt = exp_cnt + 64'd1;
        end
      end else begin
        chk("strobes_idle", {59'd0, rf_wen, csr_wen_o}, 64'd0);
      end
      if (valid_last && ready_last) sb_q.push_back(cur_exp);
    end
  end

  initial begin
    vecs[0] = mkv(32'h8000_0000, 32'h0002_a283, 1'b1, 32'hDEAD_BEEF, 32'h8000_0010, 1'b1, 5'd5,  4'b0000, 32'h0,  1'b0, 32'hDEAD_BEEF, 1'b1);
    vecs[1] = mkv(32'h8000_0004, 32'h2340_0013, 1'b0, 32'h5555_5555, 32'h0000_1234, 1'b1, 5'd0,  4'b0000, 32'h0,  1'b0, 32'h0000_1234, 1'b0);
    vecs[2] = mkv(32'h8000_0008, 32'h3052_9073, 1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  4'b0010, 32'h80, 1'b0, 32'h0,         1'b0);
    vecs[3] = mkv(32'h8000_000c, 32'h0080_00ef, 1'b0, 32'h1111_1111, 32'h8000_0010, 1'b1, 5'd1,  4'b0000, 32'h0,  1'b1, 32'h8000_0010, 1'b1);
    vecs[4] = mkv(32'h8000_0010, 32'h0000_af83, 1'b1, 32'hFFFF_FF80, 32'h0000_1000, 1'b1, 5'd31, 4'b0000, 32'h0,  1'b0, 32'hFFFF_FF80, 1'b1);
    vecs[5] = mkv(32'h8000_0014, 32'h0000_0393, 1'b0, 32'h2222_2222, 32'h0000_ABCD, 1'b0, 5'd7,  4'b0000, 32'h0,  1'b0, 32'h0000_ABCD, 1'b0);

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset release, idle.
    @(negedge clk);
    chk("rst_ready_last", {63'd0, ready_last}, 64'd1);
    chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_strobes", {59'd0, rf_wen, csr_wen_o}, 64'd0);

    // Single load, explicit latency checks.
    @(posedge clk); #1;
    commit_ready = 1'b1;
    drive(vecs[0]);
    @(posedge clk); #1;
    valid_last = 1'b0;
    @(negedge clk);
    chk("load_rf_wen", {63'd0, rf_wen}, 64'd1);
    chk("load_rf_waddr", {59'd0, rf_waddr}, 64'd5);
    chk("load_rf_wdata", rf_wdata, 64'hDEAD_BEEF);
    chk("load_instret_pre", instret, 64'd0);
    @(posedge clk); #1;
    chk("load_instret_post", instret, 64'd1);

    // Back-to-back table run with commit_ready held high.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      @(posedge clk); #1;
    end
    valid_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("b2b_instret", instret, 64'd7);

    // Backpressure: A buffered, B waiting for 3 stalled cycles.
    commit_ready = 1'b0;
    drive(vecs[4]);
    @(posedge clk); #1;
    drive(vecs[3]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready_last", {63'd0, ready_last}, 64'd0);
      chk("bp_commit_valid", {63'd0, commit_valid}, 64'd1);
      chk("bp_commit_pc", commit_pc, 64'h8000_0010);
      chk("bp_rf_wdata", rf_wdata, 64'hFFFF_FF80);
      @(posedge clk); #1;
    end
    commit_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {63'd0, ready_last}, 64'd1);
    @(posedge clk); #1;
    valid_last = 1'b0;
    chk("bp_next_pc", commit_pc, 64'h8000_000c);
    @(posedge clk); #1;
    chk("bp_instret", instret, 64'd9);
    chk("wrap_instret", {61'd0, w_instret}, 64'd1);

    // Async reset while FULL: instruction dropped without a clock edge.
    commit_ready = 1'b0;
    drive(vecs[2]);
    @(posedge clk); #1;
    valid_last = 1'b0;
    chk("pre_rst_valid", {63'd0, commit_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, commit_valid}, 64'd0);
    chk("async_rst_instret", instret, 64'd0);
    chk("async_rst_ready", {63'd0, ready_last}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    commit_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {63'd0, commit_valid}, 64'd0);
    chk("post_rst_csr", {60'd0, csr_wen_o}, 64'd0);

    // One more retire after reset.
    @(posedge clk); #1;
    drive(vecs[2]);
    @(posedge clk); #1;
    valid_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("final_instret", instret, 64'd1);
    chk("final_queue_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
